backing_mem: RTL and testbench
==============================

Name: backing_mem

Overview:
- Multi-cycle main data memory sitting directly downstream of the direct-mapped cache system.
- Serves two kinds of request:
  - Word write-through stores from the cache controller.
  - 4-word (128-bit) block refills to the cache line array.
- A fixed, parameterised access latency models slow main memory. Completion is signalled by a one-cycle ready pulse, which the cache controller uses to release its stall.

Parameters:
- ADDR_W, 10, word-address width; memory holds 2**ADDR_W 32-bit words.
- LATENCY, 4, cycles from request acceptance to ready pulse; legal range 1..15.
- BLOCK_WORDS, 4, words per refill block; fixed at 4 (block port is 128 bits).

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-low reset.
- we  input  1  word write request.
- re  input  1  block read request.
- ready  output  1  one-cycle completion pulse for the accepted request.
- addr  input  ADDR_W  word address; the block index is addr[ADDR_W-1:2].
- wd  input  32  write data.
- rd_block  output  128  refill block; word i at bits [32*i+31:32*i]; word 0 is at the block-aligned address.
- rd_count  output  32  completed-read counter (only with BACKING_MEM_STATS_EN).
- wr_count  output  32  completed-write counter (only with BACKING_MEM_STATS_EN).

Behaviour:
- Reset:
  - reset low asynchronously forces state IDLE, ready=0, rd_block=0, latency counter=0 and the latched op to none.
  - Memory array contents are NOT reset.
- State machine:
  - IDLE -> BUSY: taken when we|re is sampled high.
    - Latch addr, wd and op: write if we=1 (write has priority over a simultaneous re; the read is dropped), else read.
    - Load cnt=LATENCY-1.
  - BUSY, cnt!=0: cnt decrements.
  - BUSY, cnt==0: commit the access, go to DONE, ready=1.
    - Write: mem[latched addr] <= latched wd.
    - Read: rd_block <= {mem[b+3],mem[b+2],mem[b+1],mem[b]}, where b = latched addr with bits [1:0] cleared.
  - DONE -> IDLE unconditionally; ready=0.
- Latency:
  - Request sampled at edge E. ready is high for exactly the cycle following edge E+LATENCY.
  - With LATENCY=1, ready is high the cycle after edge E+1.
- Handshake:
  - The requester holds we/re and the address stable until ready, and deasserts them in the cycle after ready.
  - we/re, addr and wd changes during BUSY or DONE are ignored (inputs are latched at acceptance).
  - DONE is a mandatory one-cycle gap. A request still high in IDLE after DONE starts a new access.
- rd_block:
  - Holds its value until the next read commit.
  - Write commits never change rd_block, even when they target the last-read block.
- Wrap-around:
  - Block address math uses ADDR_W bits.
  - The top block (addr 1020..1023 at defaults) reads in place; there is no wrap beyond the array.
- Reset mid-access:
  - Aborts the access with no memory write and no ready pulse.
  - Any latched request is lost; the requester must re-issue.

Optional Feature:
- Macro BACKING_MEM_STATS_EN.
- Defined:
  - rd_count and wr_count ports exist.
  - Each increments by 1 at the commit edge of a read or write respectively.
  - Both reset to 0 and saturate at 32'hFFFF_FFFF.
- Undefined: the ports and counters are absent; all other behaviour is identical.

Decomposition:
- Package backing_mem_pkg holds:
  - State encoding IDLE=2'd0, BUSY=2'd1, DONE=2'd2.
  - Op encoding OP_RD, OP_WR.
  - BLOCK_W=128 and WORD_W=32.
  - Function block_base(addr), which clears bits [1:0].
- One natural sub-module, backing_mem_latency_cnt:
  - Loadable 4-bit down-counter with load, enable and zero flag.
  - Async active-low reset.

Test Plan:
- Read latency: preload mem[8..11]=32'h11,22,33,44; re=1, addr=10 -> ready high exactly in the cycle after edge +4; rd_block=128'h00000044_00000033_00000022_00000011.
- Write then read: we=1, addr=5, wd=32'hDEADBEEF, await ready; then re, addr=4 -> rd_block[63:32]=32'hDEADBEEF; rd_block is unchanged during the write access.
- Simultaneous we=re=1, addr=2, wd=32'hA5A5A5A5 -> one write only; exactly one ready pulse; rd_block unchanged; mem[2]=32'hA5A5A5A5.
- Held request: keep re=1 through ready -> DONE gap of one cycle, then a second access starts; the ready pulses are LATENCY+2 cycles apart.
- Reset mid-access: we=1, addr=7, wd=32'h1, with mem[7]=32'h0; assert reset 2 cycles after acceptance -> ready and rd_block=0 immediately; mem[7] stays 0; no ready pulse after release.
- With BACKING_MEM_STATS_EN: 3 reads and 2 writes -> rd_count=3, wr_count=2; reset -> both 0.

Source files
------------

// File: rtl/backing_mem_pkg.sv
// Shared encodings and helpers for the backing memory model.
package backing_mem_pkg;
  localparam int WORD_W      = 32;
  localparam int BLOCK_W     = 128;
  localparam int BLOCK_WORDS = 4;
  localparam int CNT_W       = 4;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] BUSY = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  typedef enum logic [1:0] {
    OP_NONE = 2'd0,
    OP_RD   = 2'd1,
    OP_WR   = 2'd2
  } op_e;

  function automatic logic [31:0] block_base(input logic [31:0] a);
    return {a[31:2], 2'b00};
  endfunction
endpackage

// File: rtl/backing_mem_latency_cnt.sv
// Loadable down-counter that times the access latency; stops at zero.
module backing_mem_latency_cnt #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load,
  input  logic         en,
  input  logic [W-1:0] load_val,
  output logic [W-1:0] cnt,
  output logic         zero
);
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)                 cnt <= '0;
    else if (load)              cnt <= load_val;
    else if (en && cnt != '0)   cnt <= cnt - 1'b1;
  end

  assign zero = (cnt == '0);
endmodule

// File: rtl/backing_mem.sv
// Multi-cycle main memory: word write-through stores and 4-word block refills.
// Optional BACKING_MEM_STATS_EN adds saturating read/write commit counters.
module backing_mem
  import backing_mem_pkg::*;
#(
  parameter int ADDR_W      = 10,
  parameter int LATENCY     = 4,
  parameter int BLOCK_WORDS = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               we,
  input  logic               re,
  output logic               ready,
  input  logic [ADDR_W-1:0]  addr,
  input  logic [WORD_W-1:0]  wd,
  output logic [BLOCK_W-1:0] rd_block
`ifdef BACKING_MEM_STATS_EN
  ,
  output logic [31:0]        rd_count,
  output logic [31:0]        wr_count
`endif
);
  typedef struct packed {
    op_e               op;
    logic [ADDR_W-1:0] addr;
    logic [WORD_W-1:0] wd;
  } req_t;

  logic [1:0]                           state;
  req_t                                 req_q;
  logic [CNT_W-1:0]                     cnt;
  logic                                 cnt_zero;
  logic                                 accept;
  logic                                 commit;
  logic [ADDR_W-1:0]                    base;
  logic [BLOCK_WORDS-1:0][WORD_W-1:0]   blk_words;
  logic [WORD_W-1:0]                    mem [2**ADDR_W];

  assign accept = (state == IDLE) && (we || re);
  assign commit = (state == BUSY) && cnt_zero;
  assign base   = ADDR_W'(block_base(32'(req_q.addr)));

  backing_mem_latency_cnt #(.W(CNT_W)) u_cnt (
    .clk      (clk),
    .reset    (reset),
    .load     (accept),
    .en       (state == BUSY),
    .load_val (CNT_W'(LATENCY - 1)),
    .cnt      (cnt),
    .zero     (cnt_zero)
  );

  // Block words are gathered in place; base has its low bits clear, so the
  // top block never runs past the array.
  for (genvar gi = 0; gi < BLOCK_WORDS; gi++) begin : g_word
    assign blk_words[gi] = mem[base | ADDR_W'(gi)];
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= IDLE;
      req_q    <= '{op: OP_NONE, addr: '0, wd: '0};
      ready    <= 1'b0;
      rd_block <= '0;
    end else begin
      ready <= commit;
      case (state)
        IDLE: if (accept) begin
          state <= BUSY;
          req_q <= '{op: we ? OP_WR : OP_RD, addr: addr, wd: wd};
        end
        BUSY: if (cnt_zero) begin
          state <= DONE;
          if (req_q.op == OP_RD) rd_block <= blk_words;
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // Array has no reset; a reset-aborted write never reaches commit.
  always_ff @(posedge clk) begin
    if (commit && req_q.op == OP_WR) mem[req_q.addr] <= req_q.wd;
  end

`ifdef BACKING_MEM_STATS_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rd_count <= '0;
      wr_count <= '0;
    end else if (commit) begin
      if (req_q.op == OP_RD && rd_count != '1) rd_count <= rd_count + 1'b1;
      if (req_q.op == OP_WR && wr_count != '1) wr_count <= wr_count + 1'b1;
    end
  end
`endif
endmodule

// File: tb/tb_backing_mem.sv
// Directed self-checking bench for backing_mem (latency, write/read, priority,
// held request, reset abort, optional stats counters).
module tb_backing_mem;
  localparam int LAT = 4;

  logic         clk = 1'b0;
  logic         reset;
  logic         we, re, ready;
  logic [9:0]   addr;
  logic [31:0]  wd;
  logic [127:0] rd_block;
`ifdef BACKING_MEM_STATS_EN
  logic [31:0]  rd_count, wr_count;
`endif

  int errors = 0;
  int checks = 0;

  backing_mem #(.ADDR_W(10), .LATENCY(LAT), .BLOCK_WORDS(4)) dut (
    .clk      (clk),
    .reset    (reset),
    .we       (we),
    .re       (re),
    .ready    (ready),
    .addr     (addr),
    .wd       (wd),
    .rd_block (rd_block)
`ifdef BACKING_MEM_STATS_EN
    ,
    .rd_count (rd_count),
    .wr_count (wr_count)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Issue one request from a negedge, wait for ready, check latency and width.
  task automatic access(input logic w, input logic r, input logic [9:0] a,
                        input logic [31:0] d, input string tag);
    int k;
    bit seen;
    logic [127:0] rb0;
    rb0 = rd_block;
    we = w; re = r; addr = a; wd = d;
    @(posedge clk);
    k = 0; seen = 0;
    while (!seen && k < 30) begin
      @(posedge clk); k++;
      @(negedge clk);
      if (ready) seen = 1;
    end
    we = 0; re = 0;
    chk({"lat_", tag}, 128'(k), 128'(LAT));
    @(negedge clk);
    chk({"pulse_", tag}, 128'(ready), 128'(0));
    if (w) chk({"rdblk_kept_", tag}, rd_block, rb0);
  endtask

  task automatic count_pulses(input int ncyc, output int n);
    n = 0;
    for (int i = 0; i < ncyc; i++) begin
      @(negedge clk);
      if (ready) n++;
    end
  endtask

  initial begin
    int p1, p2, k, n;
    reset = 0; we = 0; re = 0; addr = '0; wd = '0;
    repeat (2) @(negedge clk);
    chk("rst_ready", 128'(ready), 128'(0));
    chk("rst_rdblk", rd_block, 128'(0));
    reset = 1;
    @(negedge clk);

    // Preload block 8, then read it from a non-aligned address.
    access(1, 0, 10'd8,  32'h11, "w8");
    access(1, 0, 10'd9,  32'h22, "w9");
    access(1, 0, 10'd10, 32'h33, "w10");
    access(1, 0, 10'd11, 32'h44, "w11");
    access(0, 1, 10'd10, 32'h0,  "r10");
    chk("blk8", rd_block, 128'h00000044_00000033_00000022_00000011);

    access(1, 0, 10'd5, 32'hDEADBEEF, "w5");
    chk("blk8_after_w5", rd_block, 128'h00000044_00000033_00000022_00000011);
    access(0, 1, 10'd4, 32'h0, "r4");
    chk("blk4_w1", 128'(rd_block[63:32]), 128'(32'hDEADBEEF));

    // Simultaneous we/re: write wins, read dropped.
    begin
      logic [127:0] rb;
      rb = rd_block;
      access(1, 1, 10'd2, 32'hA5A5A5A5, "wr2");
      count_pulses(8, n);
      chk("wr2_extra_pulses", 128'(n), 128'(0));
      chk("wr2_rdblk_same", rd_block, rb);
    end
    access(0, 1, 10'd0, 32'h0, "r0");
    chk("blk0_w2", 128'(rd_block[95:64]), 128'(32'hA5A5A5A5));

    // Held request: DONE gap then a second access.
    re = 1; addr = 10'd8;
    @(posedge clk);
    k = 0; p1 = -1; p2 = -1;
    while (p2 < 0 && k < 40) begin
      @(posedge clk); k++;
      @(negedge clk);
      if (ready) begin
        if (p1 < 0) p1 = k;
        else begin p2 = k; re = 0; end
      end
    end
    re = 0;
    chk("held_first", 128'(p1), 128'(LAT));
    chk("held_gap", 128'(p2 - p1), 128'(LAT + 2));
    chk("held_blk8", rd_block, 128'h00000044_00000033_00000022_00000011);
    count_pulses(8, n);
    chk("held_no_third", 128'(n), 128'(0));

    // Reset two cycles after accepting a write.
    access(1, 0, 10'd7, 32'h0, "w7_zero");
    we = 1; addr = 10'd7; wd = 32'h1;
    @(posedge clk);
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 0;
    #1;
    chk("abort_ready", 128'(ready), 128'(0));
    chk("abort_rdblk", rd_block, 128'(0));
    we = 0;
    @(negedge clk);
    reset = 1;
    count_pulses(10, n);
    chk("abort_no_pulse", 128'(n), 128'(0));
    access(0, 1, 10'd4, 32'h0, "r4b");
    chk("abort_mem7", 128'(rd_block[127:96]), 128'(0));
    chk("abort_mem5_kept", 128'(rd_block[63:32]), 128'(32'hDEADBEEF));

    // Top block reads in place.
    access(1, 0, 10'd1023, 32'hCAFEF00D, "w1023");
    access(0, 1, 10'd1021, 32'h0, "r1021");
    chk("top_blk_w3", 128'(rd_block[127:96]), 128'(32'hCAFEF00D));

`ifdef BACKING_MEM_STATS_EN
    @(negedge clk);
    reset = 0;
    #1;
    chk("stats_rst_rd", 128'(rd_count), 128'(0));
    chk("stats_rst_wr", 128'(wr_count), 128'(0));
    @(negedge clk);
    reset = 1;
    @(negedge clk);
    access(1, 0, 10'd20, 32'h1, "s_w1");
    access(0, 1, 10'd20, 32'h0, "s_r1");
    access(1, 0, 10'd21, 32'h2, "s_w2");
    access(0, 1, 10'd22, 32'h0, "s_r2");
    access(0, 1, 10'd23, 32'h0, "s_r3");
    chk("stats_rd", 128'(rd_count), 128'(3));
    chk("stats_wr", 128'(wr_count), 128'(2));
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
